// File: rtl/imem_loader.sv
// Instruction-memory loader: turns a length-prefixed byte stream into big-endian
// 32-bit word writes from address 0. Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W    = 11,
  parameter int MAX_WORDS = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count,
  output logic              cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_RECV,
    S_WRITE,
    S_DONE,
    S_CHECK
  } state_t;

  localparam logic [15:0] LEN_MAX = 16'(MAX_WORDS);

  state_t            state;
  logic [15:0]       len_q;
  logic [23:0]       shift_q;
  logic [1:0]        byte_idx;
  logic              accept;
  logic [ADDR_W:0]   count_inc;
  logic [15:0]       len_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  assign accept    = byte_valid && byte_ready;
  assign count_inc = word_count + (ADDR_W + 1)'(1);
  assign len_next  = {len_q[15:8], byte_in};
  assign cpu_hold  = busy;

  // NOTE: all state lives in one clocked block and uses non-blocking
  // assignments only, so every output is a clean flop with no read/write races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      len_q      <= '0;
      shift_q    <= '0;
      byte_idx   <= '0;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      // wr_en is a single-cycle strobe; only the RECV->WRITE transition raises it.
      wr_en <= 1'b0;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_LEN_HI;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
          end
        end

        S_LEN_HI: begin
          if (accept) begin
            len_q[15:8] <= byte_in;
            state       <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (accept) begin
            len_q[7:0] <= byte_in;
            if (len_next == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state <= S_CHECK;
`else
              state      <= S_DONE;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              err        <= 1'b0;
`endif
            end else if (len_next > LEN_MAX) begin
              // Oversized image is rejected before any write touches memory.
              state      <= S_DONE;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              err        <= 1'b1;
            end else begin
              state    <= S_RECV;
              byte_idx <= '0;
            end
          end
        end

        S_RECV: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q   <= csum_q ^ byte_in;
`endif
            if (byte_idx == 2'd3) begin
              state      <= S_WRITE;
              byte_ready <= 1'b0;
              wr_en      <= 1'b1;
              wr_addr    <= word_count[ADDR_W-1:0];
              wr_data    <= {shift_q, byte_in};
            end else begin
              shift_q <= {shift_q[15:0], byte_in};
            end
          end
        end

        S_WRITE: begin
          word_count <= count_inc;
          if (16'(count_inc) == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state      <= S_CHECK;
            byte_ready <= 1'b1;
`else
            state      <= S_DONE;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            err        <= 1'b0;
`endif
          end else begin
            state      <= S_RECV;
            byte_ready <= 1'b1;
            byte_idx   <= '0;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (accept) begin
            state      <= S_DONE;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            err        <= (byte_in != csum_q);
          end
        end
`endif

        default: begin
          state      <= S_IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: image-level write model plus directed loads
// (normal, empty, oversized, gappy stream, mid-load reset, optional checksum).
module tb_imem_loader;

  localparam int ADDR_W    = 11;
  localparam int MAX_WORDS = 2048;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_count;
  logic              cpu_hold;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count),
    .cpu_hold   (cpu_hold)
  );

  int n_tests = 0;
  int n_fail  = 0;

  wr_t  exp_q[$];
  wr_t  seen_q[$];
  logic exp_err;
  int   exp_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Image -> expected writes and final status, straight from the stream format.
  task automatic build_model(input byte_q_t img);
    int   len;
    logic [7:0] x;
    exp_q.delete();
    len = {img[0], img[1]};
    x   = 8'h00;
    if (len > MAX_WORDS) begin
      exp_err = 1'b1;
      exp_cnt = 0;
    end else begin
      for (int w = 0; w < len; w++) begin
        wr_t e;
        e.addr = ADDR_W'(w);
        e.data = {img[2+4*w], img[3+4*w], img[4+4*w], img[5+4*w]};
        exp_q.push_back(e);
        for (int k = 0; k < 4; k++) x = x ^ img[2+4*w+k];
      end
      exp_cnt = len;
`ifdef IMEM_LOADER_CHECKSUM_EN
      exp_err = (img[2+4*len] != x);
`else
      exp_err = 1'b0;
`endif
    end
  endtask

  // Appends the correct trailing checksum when the checksum build is active.
  function automatic byte_q_t with_csum(input byte_q_t img);
    byte_q_t    r;
    logic [7:0] x;
    r = img;
    x = 8'h00;
    for (int i = 2; i < img.size(); i++) x = x ^ img[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
    r.push_back(x);
`endif
    return r;
  endfunction

  // Cycle-by-cycle compare of the write port against the expected write list.
  always @(negedge clk) begin
    if (!rst) begin
      check("cpu_hold_vs_busy", {63'd0, cpu_hold}, {63'd0, busy});
      if (wr_en) begin
        wr_t w;
        w.addr = wr_addr;
        w.data = wr_data;
        seen_q.push_back(w);
        check("ready_low_in_write", {63'd0, byte_ready}, 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", {63'd0, wr_en}, 64'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 64'(wr_addr), 64'(e.addr));
          check("wr_data", 64'(wr_data), 64'(e.data));
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit sent;
    sent = 1'b0;
    for (int i = 0; i < 100 && !sent; i++) begin
      @(negedge clk);
      byte_in    = b;
      byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (byte_valid && byte_ready) sent = 1'b1;
    end
    check("send_timeout", {63'd0, sent}, 64'd1);
  endtask

  task automatic send_image(input byte_q_t img, input bit gaps);
    foreach (img[i]) send_byte(img[i], gaps);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    while (!done && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("done_reached", {63'd0, done}, 64'd1);
  endtask

  task automatic final_status(input string tag);
    check({tag, "_done"},   {63'd0, done}, 64'd1);
    check({tag, "_busy"},   {63'd0, busy}, 64'd0);
    check({tag, "_err"},    {63'd0, err},  {63'd0, exp_err});
    check({tag, "_count"},  64'(word_count), 64'(exp_cnt));
    check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic reset_values(input string tag);
    check({tag, "_byte_ready"}, {63'd0, byte_ready}, 64'd0);
    check({tag, "_wr_en"},      {63'd0, wr_en},      64'd0);
    check({tag, "_busy"},       {63'd0, busy},       64'd0);
    check({tag, "_done"},       {63'd0, done},       64'd0);
    check({tag, "_err"},        {63'd0, err},        64'd0);
    check({tag, "_cpu_hold"},   {63'd0, cpu_hold},   64'd0);
    check({tag, "_wr_addr"},    64'(wr_addr),        64'd0);
    check({tag, "_wr_data"},    64'(wr_data),        64'd0);
    check({tag, "_word_count"}, 64'(word_count),     64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t img2, img;

    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    #1;
    reset_values("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Two-word image, continuous stream; a second start while busy is ignored.
    img2 = with_csum('{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                       8'hDE, 8'hAD, 8'hBE, 8'hEF});
    build_model(img2);
    seen_q.delete();
    pulse_start();
    check("t1_busy_after_start", {63'd0, busy}, 64'd1);
    check("t1_ready_after_start", {63'd0, byte_ready}, 64'd1);
    pulse_start();
    send_image(img2, 1'b0);
    wait_done();
    final_status("t1");
    check("t1_nwrites", 64'(seen_q.size()), 64'd2);
    check("t1_w0_addr", 64'(seen_q[0].addr), 64'd0);
    check("t1_w0_data", 64'(seen_q[0].data), 64'h12345678);
    check("t1_w1_addr", 64'(seen_q[1].addr), 64'd1);
    check("t1_w1_data", 64'(seen_q[1].data), 64'hDEADBEEF);
    check("t1_count_lit", 64'(word_count), 64'd2);

    // Empty image.
    img = with_csum('{8'h00, 8'h00});
    build_model(img);
    seen_q.delete();
    pulse_start();
    send_image(img, 1'b0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    check("t2_done_after_header", {63'd0, done}, 64'd1);
`endif
    wait_done();
    final_status("t2");
    check("t2_err_lit", {63'd0, err}, 64'd0);
    check("t2_nwrites", 64'(seen_q.size()), 64'd0);

    // Oversized image: 2049 words.
    img = '{8'h08, 8'h01};
    build_model(img);
    seen_q.delete();
    pulse_start();
    send_image(img, 1'b0);
    wait_done();
    final_status("t3");
    check("t3_err_lit", {63'd0, err}, 64'd1);
    check("t3_nwrites", 64'(seen_q.size()), 64'd0);

    // Same two-word image with random valid gaps.
    build_model(img2);
    seen_q.delete();
    pulse_start();
    send_image(img2, 1'b1);
    wait_done();
    final_status("t4");
    check("t4_w1_data", 64'(seen_q[1].data), 64'hDEADBEEF);

    // Reset after six payload bytes: one word written, then everything clears.
    build_model(img2);
    seen_q.delete();
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(img2[i], 1'b0);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    byte_valid = 1'b0;
    #1;
    reset_values("t5_rst");
    check("t5_nwrites", 64'(seen_q.size()), 64'd1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    build_model(img2);
    seen_q.delete();
    pulse_start();
    send_image(img2, 1'b0);
    wait_done();
    final_status("t5_reload");
    check("t5_reload_nwrites", 64'(seen_q.size()), 64'd2);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum good, then checksum bad (word still written).
    img = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    build_model(img);
    seen_q.delete();
    pulse_start();
    send_image(img, 1'b0);
    wait_done();
    final_status("t6_good");
    check("t6_good_err_lit", {63'd0, err}, 64'd0);

    img = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    build_model(img);
    seen_q.delete();
    pulse_start();
    send_image(img, 1'b0);
    wait_done();
    final_status("t6_bad");
    check("t6_bad_err_lit", {63'd0, err}, 64'd1);
    check("t6_bad_w0_data", 64'(seen_q[0].data), 64'h01020304);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
